// File: rtl/dual_deque_pkg.sv
// dual_deque_pkg: shared operation and FSM state encodings for the dual deque controller
package dual_deque_pkg;
  typedef enum logic [1:0] {PUSH_BACK, PUSH_FRONT, POP_BACK, POP_FRONT} op_t;
  typedef enum logic [1:0] {IDLE, EXEC, READ, RESP} state_t;
endpackage

// File: rtl/deque_ptr.sv
// deque_ptr: head/count pair of one circular deque, its access index and empty/full flags
module deque_ptr
  import dual_deque_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  op_t           op_i,
  output logic [AW-2:0] idx_o,
  output logic [AW-1:0] cnt_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam logic [AW-2:0] IONE = 1;
  localparam logic [AW-1:0] CONE = 1;
  localparam logic [AW-1:0] HALF = {1'b1, {(AW-1){1'b0}}};
  logic [AW-2:0] h_q, h_d, cl;
  logic [AW-1:0] c_q, c_d;
  assign cl = c_q[AW-2:0];
  always_comb begin
    idx_o = op_i == PUSH_BACK  ? h_q + cl :
            op_i == PUSH_FRONT ? h_q - IONE :
            op_i == POP_FRONT  ? h_q : h_q + cl - IONE;
    h_d = !en_i ? h_q :
          op_i == PUSH_FRONT ? h_q - IONE :
          op_i == POP_FRONT  ? h_q + IONE : h_q;
    c_d = !en_i ? c_q : op_i[1] ? c_q - CONE : c_q + CONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      c_q <= '0;
    end else begin
      h_q <= h_d;
      c_q <= c_d;
    end
  end
  assign cnt_o   = c_q;
  assign empty_o = c_q == '0;
  assign full_o  = c_q == HALF;
endmodule

// File: rtl/dual_deque_ctrl.sv
// dual_deque_ctrl: two circular byte deques sharing one RAM with 1-cycle registered read data
module dual_deque_ctrl
  import dual_deque_pkg::*;
#(
  parameter  int RAM_BYTES = 64,
  localparam int AW        = $clog2(RAM_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_sel,
  input  logic [1:0]    cmd_op,
  input  logic [7:0]    cmd_data,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [7:0]    rsp_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [AW-1:0] count0,
  output logic [AW-1:0] count1,
  output logic [1:0]    empty,
  output logic [1:0]    full
);
  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic          sel_q, sel_d, err_q, err_d, acc, exec_ok;
  logic [7:0]    data_q, data_d;
  logic [AW-2:0] idx0, idx1;
  deque_ptr #(.AW(AW)) u_dq0 (
    .clk(clk), .rst(rst), .en_i(exec_ok && !sel_q), .op_i(op_q),
    .idx_o(idx0), .cnt_o(count0), .empty_o(empty[0]), .full_o(full[0])
  );
  deque_ptr #(.AW(AW)) u_dq1 (
    .clk(clk), .rst(rst), .en_i(exec_ok && sel_q), .op_i(op_q),
    .idx_o(idx1), .cnt_o(count1), .empty_o(empty[1]), .full_o(full[1])
  );
  assign cmd_ready = state_q == IDLE && !rst;
  assign acc       = cmd_valid && cmd_ready;
  assign exec_ok   = state_q == EXEC && !err_q;
  assign mem_addr  = exec_ok ? {sel_q, sel_q ? idx1 : idx0} : '0;
  assign mem_wr_en = exec_ok && !op_q[1] && !rst;
  assign mem_wdata = data_q;
  assign rsp_valid = state_q == RESP && !rst;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_data  = rsp_valid && op_q[1] && !err_q ? data_q : 8'h00;
  // The full/empty decision is frozen at accept so EXEC never re-evaluates it.
  always_comb begin
    state_d = state_q == IDLE ? (acc ? EXEC : IDLE) :
              state_q == EXEC ? ((err_q || !op_q[1]) ? RESP : READ) :
              state_q == READ ? RESP : IDLE;
    sel_d   = acc ? cmd_sel : sel_q;
    op_d    = acc ? op_t'(cmd_op) : op_q;
    err_d   = acc ? (cmd_op[1] ? empty[cmd_sel] : full[cmd_sel]) : err_q;
    data_d  = acc ? cmd_data : state_q == READ ? mem_rdata : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= PUSH_BACK;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_dual_deque_ctrl.sv
// tb_dual_deque_ctrl: queue-based reference model with per-cycle output comparison
module tb_dual_deque_ctrl;
  localparam int RB = 64, AW = 6, HALF = 32;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_ready, cmd_sel = 0, rsp_valid, rsp_err, mem_wr_en;
  logic [1:0] cmd_op = 0, empty, full;
  logic [7:0] cmd_data = 0, rsp_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr, count0, count1;
  dual_deque_ctrl #(.RAM_BYTES(RB)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .count0(count0), .count1(count1),
    .empty(empty), .full(full)
  );
  logic [7:0] ram [RB];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end
  logic [7:0] dq [2][$];
  int hd [2], cnt [2];
  logic e_ready = 0, e_wr = 0, e_rv = 0, e_err = 0, e_achk = 1, chk_en = 0;
  logic [AW-1:0] e_addr = 0;
  logic [7:0] e_wdata = 0, e_rdata = 0;
  int n_tot = 0, n_bad = 0, wr_cnt = 0, hi_writes = 0, last_wa = -1, last_rd = -1, last_err = -1;
  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("cmd_ready", cmd_ready, e_ready);
    chk("mem_wr_en", mem_wr_en, e_wr);
    if (e_achk) chk("mem_addr", mem_addr, e_addr);
    if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_err", rsp_err, e_err);
    chk("rsp_data", rsp_data, e_rv ? e_rdata : 0);
    chk("count0", count0, cnt[0]);
    chk("count1", count1, cnt[1]);
    chk("empty", empty, {cnt[1] == 0, cnt[0] == 0});
    chk("full", full, {cnt[1] == HALF, cnt[0] == HALF});
    if (mem_wr_en) begin
      wr_cnt++;
      last_wa = mem_addr;
      if (mem_addr >= HALF) hi_writes++;
    end
    if (rsp_valid) begin
      last_rd = rsp_data;
      last_err = rsp_err;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_state();
    e_ready = 1; e_wr = 0; e_rv = 0; e_err = 0; e_rdata = 0; e_addr = 0; e_achk = 1;
  endtask
  task automatic garbage();
    cmd_valid = 1'($urandom); cmd_sel = 1'($urandom); cmd_op = 2'($urandom); cmd_data = 8'($urandom);
  endtask
  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      dq[i].delete();
      hd[i] = 0;
      cnt[i] = 0;
    end
  endtask
  task automatic do_reset();
    rst = 1; e_ready = 0;
    tick();
    clear_model();
    tick();
    rst = 0;
    idle_state();
  endtask
  task automatic cmd(input int sel, input int op, input logic [7:0] d);
    int sz, addr, err;
    logic [7:0] v;
    sz = dq[sel].size();
    err = op >= 2 ? int'(sz == 0) : int'(sz == HALF);
    v = 0;
    addr = 0;
    if (err == 0) begin
      case (op)
        0: begin addr = (hd[sel] + sz) % HALF; dq[sel].push_back(d); end
        1: begin hd[sel] = (hd[sel] + HALF - 1) % HALF; addr = hd[sel]; dq[sel].push_front(d); end
        2: begin addr = (hd[sel] + sz - 1) % HALF; v = dq[sel].pop_back(); end
        default: begin addr = hd[sel]; hd[sel] = (hd[sel] + 1) % HALF; v = dq[sel].pop_front(); end
      endcase
      addr += sel * HALF;
    end
    cmd_valid = 1; cmd_sel = sel[0]; cmd_op = op[1:0]; cmd_data = d;
    tick();
    garbage();
    e_ready = 0; e_wr = op < 2 && err == 0; e_wdata = d; e_addr = AW'(addr); e_achk = err == 0;
    tick();
    garbage();
    e_wr = 0; e_addr = 0; e_achk = 1; cnt[sel] = dq[sel].size();
    if (err == 0 && op >= 2) tick();
    e_rv = 1; e_err = err != 0; e_rdata = v;
    tick();
    cmd_valid = 0;
    idle_state();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    int w0, h0, sel, op, pushy;
    clear_model();
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    idle_state();
    tick();
    cmd(0, 0, 8'h11);
    chk("t1_waddr", last_wa, 0);
    chk("t1_count0", count0, 1);
    chk("t1_empty", empty, 2);
    do_reset();
    cmd(1, 1, 8'hAA);
    chk("t2_waddr", last_wa, 63);
    cmd(1, 3, 8'h00);
    chk("t2_rdata", last_rd, 8'hAA);
    chk("t2_empty", empty, 3);
    do_reset();
    cmd(0, 0, 8'h11);
    cmd(0, 0, 8'h22);
    cmd(0, 2, 8'h00);
    chk("t3_popback", last_rd, 8'h22);
    chk("t3_count0", count0, 1);
    cmd(0, 3, 8'h00);
    chk("t3_popfront", last_rd, 8'h11);
    do_reset();
    w0 = wr_cnt;
    cmd(0, 2, 8'h00);
    chk("t4_err", last_err, 1);
    chk("t4_rdata", last_rd, 0);
    chk("t4_nowrite", wr_cnt - w0, 0);
    chk("t4_count0", count0, 0);
    do_reset();
    h0 = hi_writes;
    for (int i = 0; i < 32; i++) cmd(0, 0, 8'(i + 1));
    chk("t5_full", full, 1);
    chk("t5_count0", count0, 32);
    w0 = wr_cnt;
    cmd(0, 0, 8'h99);
    chk("t5_err", last_err, 1);
    chk("t5_nowrite", wr_cnt - w0, 0);
    cmd(0, 3, 8'h00);
    chk("t5_popfront", last_rd, 1);
    cmd(0, 0, 8'h5A);
    chk("t5_wrap_addr", last_wa, 0);
    chk("t5_hi_untouched", hi_writes - h0, 0);
    do_reset();
    w0 = wr_cnt;
    cmd_valid = 1; cmd_sel = 0; cmd_op = 2'b00; cmd_data = 8'h77;
    tick();
    rst = 1; cmd_valid = 0;
    e_ready = 0; e_wr = 0; e_achk = 0; e_rv = 0;
    tick();
    clear_model();
    rst = 0;
    idle_state();
    tick();
    tick();
    chk("t6_nowrite", wr_cnt - w0, 0);
    chk("t6_count0", count0, 0);
    chk("t6_empty", empty, 3);
    do_reset();
    for (int k = 0; k < 400; k++) begin
      pushy = k < 200 ? 7 : 3;
      sel = $urandom_range(1, 0);
      op = $urandom_range(9, 0) < pushy ? $urandom_range(1, 0) : $urandom_range(3, 2);
      cmd(sel, op, 8'($urandom));
      for (int g = $urandom_range(2, 0); g > 0; g--) tick();
    end
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
